hcsr04_scan_controller: RTL and testbench

Sequences up to NUM_SENSORS HC-SR04 sensors that share one echo-measurement/divider datapath. For each enabled sensor in round-robin order it:
- generates the trigger pulse,
- steers that sensor's echo into the shared echo block,
- waits for the measurement or a timeout,
- captures the divider result after its pipeline latency,
- enforces the inter-ping gap.

It sits between the sensor pins and the echo/divide block, and presents one tagged result stream to the host logic.

---
 rtl/hcsr04_scan_controller_pkg.sv | 30 +++
 rtl/hcsr04_rr_select.sv | 43 ++++
 rtl/hcsr04_scan_controller.sv | 201 ++++++++++++++++++++
 tb/tb_hcsr04_scan_controller.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hcsr04_scan_controller_pkg.sv
// Shared definitions for the HC-SR04 scan controller: FSM states, logic
// levels, sensor-id width and default cycle counts derived from the clock.
package hcsr04_scan_controller_pkg;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;

    localparam int CLK_FREQ_HZ = 50_000_000;
    localparam int SENSOR_ID_W = 3;

    // 10 us trigger, 38 ms echo timeout, 60 ms inter-ping gap.
    localparam int DEF_TRIG_CYCLES    = CLK_FREQ_HZ / 100_000;
    localparam int DEF_TIMEOUT_CYCLES = (CLK_FREQ_HZ / 1000) * 38;
    localparam int DEF_GAP_CYCLES     = (CLK_FREQ_HZ / 1000) * 60;
    localparam int DEF_DIV_LATENCY    = 30;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIGGER,
        ST_WAIT_RISE,
        ST_WAIT_DONE,
        ST_CAPTURE,
        ST_GAP
    } scan_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hcsr04_rr_select.sv
// Round-robin pick: next set mask bit strictly after i_idx, wrapping
// modulo NUM_SENSORS. i_idx must be below NUM_SENSORS.
module hcsr04_rr_select
    import hcsr04_scan_controller_pkg::*;
#(
    parameter int NUM_SENSORS = 4
) (
    input  logic [NUM_SENSORS-1:0] i_mask,
    input  logic [SENSOR_ID_W-1:0] i_idx,
    output logic [SENSOR_ID_W-1:0] o_idx,
    output logic                   o_found
);

    localparam int N = NUM_SENSORS;

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [4:0]     w_shift;
    logic [2:0]     w_pos;
    logic [4:0]     w_sum;

    // Doubling the mask turns the wrap into a plain right shift; bit 0 of
    // w_rot then corresponds to sensor i_idx+1.
    assign w_dbl   = {i_mask, i_mask};
    assign w_shift = {2'b00, i_idx} + 5'd1;
    assign w_rot   = N'(w_dbl >> w_shift);

    // Lowest set bit of the rotated mask is the nearest candidate.
    always_comb begin
        w_pos = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_pos = 3'(i);
            end
        end
    end

    // w_shift <= N and w_pos < N, so one conditional subtract is enough.
    assign w_sum   = w_shift + {2'b00, w_pos};
    assign o_idx   = (w_sum >= 5'(N)) ? SENSOR_ID_W'(w_sum - 5'(N)) : SENSOR_ID_W'(w_sum);
    assign o_found = |i_mask;

endmodule

// File: rtl/hcsr04_scan_controller.sv
// Round-robin sequencer for up to eight HC-SR04 sensors sharing one
// echo-measurement/divider block; publishes one tagged result stream.
module hcsr04_scan_controller
    import hcsr04_scan_controller_pkg::*;
#(
    parameter int NUM_SENSORS    = 4,
    parameter int DIST_W         = 44,
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int DIV_LATENCY    = DEF_DIV_LATENCY
) (
    input  logic                   Clk_i,
    input  logic                   Reset_i,
    input  logic                   Enable_i,
    input  logic [NUM_SENSORS-1:0] Sensor_mask_i,
    input  logic [NUM_SENSORS-1:0] Echo_i,
    output logic [NUM_SENSORS-1:0] Trig_o,
    output logic                   Echo_sel_o,
    input  logic                   Meas_done_i,
    input  logic [DIST_W-1:0]      Meas_distance_i,
    output logic [DIST_W-1:0]      Distance_o,
    output logic [2:0]             Sensor_id_o,
    output logic                   Valid_o,
    output logic                   Timeout_o,
    output logic                   Busy_o
);

    localparam int CNT_MAX = max_int(max_int(TRIG_CYCLES, TIMEOUT_CYCLES),
                                     max_int(GAP_CYCLES, DIV_LATENCY));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(DIV_LATENCY - 1);

    scan_state_t            r_state;
    scan_state_t            w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [SENSOR_ID_W-1:0] r_sel;
    logic [SENSOR_ID_W-1:0] w_rr_idx;
    logic                   w_rr_found;
    logic [NUM_SENSORS-1:0] w_sel_onehot;
    logic                   w_echo_cur;
    logic                   w_at_timeout;
    logic                   w_cnt_clr;
    logic                   w_sel_load;
    logic                   w_pub_meas;
    logic                   w_pub_to;
    logic                   w_trig_en;
    logic                   w_echo_en;
    logic [DIST_W-1:0]      r_distance;
    logic [2:0]             r_sensor_id;
    logic                   r_valid;
    logic                   r_timeout;

    hcsr04_rr_select #(
        .NUM_SENSORS (NUM_SENSORS)
    ) u_rr_select (
        .i_mask  (Sensor_mask_i),
        .i_idx   (r_sel),
        .o_idx   (w_rr_idx),
        .o_found (w_rr_found)
    );

    // Decode the selected sensor once; it gates both trigger and echo paths.
    generate
        for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_sensor
            assign w_sel_onehot[gi] = (r_sel == SENSOR_ID_W'(gi));
            assign Trig_o[gi]       = w_trig_en & w_sel_onehot[gi];
        end
    endgenerate

    assign w_echo_cur   = |(Echo_i & w_sel_onehot);
    assign w_at_timeout = (r_cnt == TO_LAST);
    assign Echo_sel_o   = w_echo_en & w_echo_cur;
    assign Busy_o       = (r_state != ST_IDLE);

    // Next-state and strobe decode; a timeout blanks the echo path in the
    // same cycle so the echo block sees a clean fall.
    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = LOW;
        w_sel_load   = LOW;
        w_pub_meas   = LOW;
        w_pub_to     = LOW;
        w_trig_en    = LOW;
        w_echo_en    = LOW;
        case (r_state)
            ST_IDLE: begin
                if (Enable_i && w_rr_found) begin
                    w_sel_load   = HIGH;
                    w_cnt_clr    = HIGH;
                    w_state_next = ST_TRIGGER;
                end
            end
            ST_TRIGGER: begin
                w_trig_en = HIGH;
                if (r_cnt == TRIG_LAST) begin
                    w_cnt_clr    = HIGH;
                    w_state_next = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                w_echo_en = !w_at_timeout;
                if (w_at_timeout) begin
                    w_pub_to     = HIGH;
                    w_cnt_clr    = HIGH;
                    w_state_next = ST_GAP;
                end else if (w_echo_cur) begin
                    w_state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                w_echo_en = !w_at_timeout;
                if (Meas_done_i) begin
                    w_cnt_clr    = HIGH;
                    w_state_next = ST_CAPTURE;
                end else if (w_at_timeout) begin
                    w_pub_to     = HIGH;
                    w_cnt_clr    = HIGH;
                    w_state_next = ST_GAP;
                end
            end
            ST_CAPTURE: begin
                if (r_cnt == LAT_LAST) begin
                    w_pub_meas   = HIGH;
                    w_cnt_clr    = HIGH;
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_clr    = HIGH;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Shared phase counter; keeps running across WAIT_RISE -> WAIT_DONE.
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            r_cnt <= '0;
        end else if (w_cnt_clr || r_state == ST_IDLE) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Current sensor index; starts at the top so the first pick is the lowest set bit.
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            r_sel <= SENSOR_ID_W'(NUM_SENSORS - 1);
        end else if (w_sel_load) begin
            r_sel <= w_rr_idx;
        end
    end

    // Result registers hold between Valid_o pulses.
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            r_distance  <= '0;
            r_sensor_id <= '0;
            r_valid     <= LOW;
            r_timeout   <= LOW;
        end else if (w_pub_meas) begin
            r_distance  <= Meas_distance_i;
            r_sensor_id <= r_sel;
            r_valid     <= HIGH;
            r_timeout   <= LOW;
        end else if (w_pub_to) begin
            r_distance  <= '1;
            r_sensor_id <= r_sel;
            r_valid     <= HIGH;
            r_timeout   <= HIGH;
        end else begin
            r_valid     <= LOW;
        end
    end

    assign Distance_o  = r_distance;
    assign Sensor_id_o = r_sensor_id;
    assign Valid_o     = r_valid;
    assign Timeout_o   = r_timeout;

endmodule

// File: tb/tb_hcsr04_scan_controller.sv
// Directed bench for hcsr04_scan_controller with a small sensor and
// echo-block model (TRIG=5, TIMEOUT=100, GAP=20, DIV_LATENCY=3, 4 sensors).
module tb_hcsr04_scan_controller;

    localparam int N    = 4;
    localparam int DW   = 44;
    localparam int TRIG = 5;
    localparam int TMO  = 100;
    localparam int GAP  = 20;
    localparam int LAT  = 3;

    logic          Clk_i = 1'b0;
    logic          Reset_i = 1'b0;
    logic          Enable_i = 1'b0;
    logic [N-1:0]  Sensor_mask_i = '0;
    logic [N-1:0]  Echo_i = '0;
    logic [N-1:0]  Trig_o;
    logic          Echo_sel_o;
    logic          Meas_done_i = 1'b0;
    logic [DW-1:0] Meas_distance_i = '0;
    logic [DW-1:0] Distance_o;
    logic [2:0]    Sensor_id_o;
    logic          Valid_o;
    logic          Timeout_o;
    logic          Busy_o;

    int errors = 0;
    int checks = 0;

    // model state
    int            cyc = 0;
    int            echo_len[N] = '{40, 40, 40, 40};
    int            echo_s = 0, echo_wait = 0, echo_left = 0, meas_s = 0;
    logic          pend = 1'b0, prev_sel = 1'b0, sel_now;
    logic [N-1:0]  prev_trig = '0, trig_seen = '0;
    int            trig_start[N], trig_fall_cyc[N];
    int            multi_trig = 0;
    int            trig_q[$], trig_start_q[$], trig_len_q[$];
    int            v_id_q[$], v_to_q[$], v_cyc_q[$];
    logic [DW-1:0] v_dist_q[$];

    hcsr04_scan_controller #(
        .NUM_SENSORS    (N),
        .DIST_W         (DW),
        .TRIG_CYCLES    (TRIG),
        .TIMEOUT_CYCLES (TMO),
        .GAP_CYCLES     (GAP),
        .DIV_LATENCY    (LAT)
    ) dut (
        .Clk_i           (Clk_i),
        .Reset_i         (Reset_i),
        .Enable_i        (Enable_i),
        .Sensor_mask_i   (Sensor_mask_i),
        .Echo_i          (Echo_i),
        .Trig_o          (Trig_o),
        .Echo_sel_o      (Echo_sel_o),
        .Meas_done_i     (Meas_done_i),
        .Meas_distance_i (Meas_distance_i),
        .Distance_o      (Distance_o),
        .Sensor_id_o     (Sensor_id_o),
        .Valid_o         (Valid_o),
        .Timeout_o       (Timeout_o),
        .Busy_o          (Busy_o)
    );

    always #5 Clk_i = ~Clk_i;

    // Sensor + echo-block model: echo rises one cycle after trigger fall and
    // stays high echo_len cycles (0 = never); Meas_done pulses one cycle after
    // Echo_sel_o falls, carrying distance sensor*10+1.
    initial begin : model
        forever begin
            @(posedge Clk_i);
            #1;
            cyc++;
            sel_now = Echo_sel_o;
            for (int s = 0; s < N; s++) begin
                if (Trig_o[s] && !prev_trig[s]) begin
                    trig_q.push_back(s);
                    trig_start_q.push_back(cyc);
                    trig_start[s] = cyc;
                end
                if (!Trig_o[s] && prev_trig[s]) begin
                    trig_len_q.push_back(cyc - trig_start[s]);
                    trig_fall_cyc[s] = cyc;
                    if (Reset_i) begin
                        echo_s    = s;
                        echo_wait = 2;
                        echo_left = echo_len[s];
                    end
                end
            end
            trig_seen |= Trig_o;
            if ($countones(Trig_o) > 1) multi_trig++;
            if (Valid_o) begin
                v_id_q.push_back(int'(Sensor_id_o));
                v_dist_q.push_back(Distance_o);
                v_to_q.push_back(int'(Timeout_o));
                v_cyc_q.push_back(cyc);
                $display("result id=%0d dist=%0d timeout=%0b cycle=%0d", Sensor_id_o, Distance_o, Timeout_o, cyc);
            end
            if (!Reset_i) begin
                Echo_i      = '0;
                echo_wait   = 0;
                echo_left   = 0;
                pend        = 1'b0;
                Meas_done_i = 1'b0;
            end else begin
                Meas_done_i = pend;
                if (pend) Meas_distance_i = DW'(meas_s * 10 + 1);
                pend = prev_sel && !sel_now;
                if (pend) meas_s = echo_s;
                if (echo_wait > 0) begin
                    echo_wait--;
                    if (echo_wait == 0 && echo_left > 0) Echo_i[echo_s] = 1'b1;
                end else if (echo_left > 0) begin
                    echo_left--;
                    if (echo_left == 0) Echo_i = '0;
                end
            end
            prev_sel  = sel_now;
            prev_trig = Trig_o;
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        trig_q.delete(); trig_start_q.delete(); trig_len_q.delete();
        v_id_q.delete(); v_dist_q.delete(); v_to_q.delete(); v_cyc_q.delete();
        trig_seen  = '0;
        multi_trig = 0;
    endtask

    task automatic do_reset(input logic [N-1:0] mask);
        Enable_i = 1'b0;
        @(negedge Clk_i);
        Reset_i = 1'b0;
        Sensor_mask_i = mask;
        repeat (3) @(negedge Clk_i);
        clear_logs();
        Reset_i = 1'b1;
    endtask

    task automatic test_reset();
        Enable_i = 1'b1; Sensor_mask_i = 4'b1111; Reset_i = 1'b0;
        repeat (2) @(negedge Clk_i);
        checks++; if (Trig_o !== 4'b0000) begin errors++; $display("FAIL reset_trig: got %b want 0000", Trig_o); end
        checks++; if (Echo_sel_o !== 1'b0) begin errors++; $display("FAIL reset_echo_sel: got %b want 0", Echo_sel_o); end
        checks++; if (Distance_o !== '0) begin errors++; $display("FAIL reset_distance: got %0h want 0", Distance_o); end
        checks++; if (Sensor_id_o !== 3'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", Sensor_id_o); end
        checks++; if (Valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", Valid_o); end
        checks++; if (Timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", Timeout_o); end
        checks++; if (Busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy_o); end
        Reset_i = 1'b1;
        @(negedge Clk_i);
        checks++; if (Trig_o !== 4'b0001) begin errors++; $display("FAIL reset_first_pick: got %b want 0001", Trig_o); end
        checks++; if (Busy_o !== 1'b1) begin errors++; $display("FAIL reset_busy_after: got %b want 1", Busy_o); end
    endtask

    task automatic test_round_robin();
        int n;
        int exp_id[5]   = '{0, 1, 2, 3, 0};
        int exp_dist[5] = '{1, 11, 21, 31, 1};
        for (int s = 0; s < N; s++) echo_len[s] = 40;
        do_reset(4'b1111);
        Enable_i = 1'b1;
        n = 0;
        while (v_id_q.size() < 5 && n < 2000) begin @(negedge Clk_i); n++; end
        checks++;
        if (v_id_q.size() < 5) begin
            errors++; $display("FAIL rr_results: got %0d results want 5", v_id_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (v_id_q[i] != exp_id[i]) begin errors++; $display("FAIL rr_id[%0d]: got %0d want %0d", i, v_id_q[i], exp_id[i]); end
                checks++; if (v_dist_q[i] !== DW'(exp_dist[i])) begin errors++; $display("FAIL rr_dist[%0d]: got %0d want %0d", i, v_dist_q[i], exp_dist[i]); end
                checks++; if (v_to_q[i] != 0) begin errors++; $display("FAIL rr_timeout[%0d]: got %0d want 0", i, v_to_q[i]); end
            end
            for (int i = 0; i < 4; i++) begin
                checks++; if (trig_len_q[i] != TRIG) begin errors++; $display("FAIL rr_trig_len[%0d]: got %0d want %0d", i, trig_len_q[i], TRIG); end
                checks++; if (trig_start_q[i+1] - trig_start_q[i] < TRIG + GAP) begin
                    errors++; $display("FAIL rr_spacing[%0d]: got %0d want >= %0d", i, trig_start_q[i+1] - trig_start_q[i], TRIG + GAP);
                end
            end
        end
        checks++; if (multi_trig != 0) begin errors++; $display("FAIL rr_onehot: got %0d multi-hot cycles want 0", multi_trig); end
    endtask

    task automatic test_mask_pattern();
        int n;
        int exp_ord[4] = '{1, 3, 1, 3};
        do_reset(4'b1010);
        Enable_i = 1'b1;
        n = 0;
        while (trig_q.size() < 4 && n < 2000) begin @(negedge Clk_i); n++; end
        checks++;
        if (trig_q.size() < 4) begin
            errors++; $display("FAIL mask_triggers: got %0d triggers want 4", trig_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (trig_q[i] != exp_ord[i]) begin errors++; $display("FAIL mask_order[%0d]: got %0d want %0d", i, trig_q[i], exp_ord[i]); end
            end
        end
        checks++; if (trig_seen[0] !== 1'b0 || trig_seen[2] !== 1'b0) begin
            errors++; $display("FAIL mask_unselected: got trig_seen=%b want bits 0,2 clear", trig_seen);
        end
    endtask

    task automatic test_timeout_no_echo();
        int n;
        echo_len[2] = 0;
        do_reset(4'b1111);
        Enable_i = 1'b1;
        n = 0;
        while (v_id_q.size() < 4 && n < 2000) begin @(negedge Clk_i); n++; end
        checks++;
        if (v_id_q.size() < 4) begin
            errors++; $display("FAIL to_results: got %0d results want 4", v_id_q.size());
        end else begin
            checks++; if (v_id_q[2] != 2) begin errors++; $display("FAIL to_id: got %0d want 2", v_id_q[2]); end
            checks++; if (v_to_q[2] != 1) begin errors++; $display("FAIL to_flag: got %0d want 1", v_to_q[2]); end
            checks++; if (v_dist_q[2] !== {DW{1'b1}}) begin errors++; $display("FAIL to_dist: got %0h want all ones", v_dist_q[2]); end
            checks++; if (v_cyc_q[2] - trig_fall_cyc[2] != TMO) begin
                errors++; $display("FAIL to_latency: got %0d want %0d", v_cyc_q[2] - trig_fall_cyc[2], TMO);
            end
            checks++; if (v_id_q[3] != 3 || v_to_q[3] != 0) begin
                errors++; $display("FAIL to_continue: got id=%0d to=%0d want id=3 to=0", v_id_q[3], v_to_q[3]);
            end
        end
        echo_len[2] = 40;
    endtask

    task automatic test_stuck_echo();
        int n, vcount;
        echo_len[1] = 150;
        do_reset(4'b0010);
        Enable_i = 1'b1;
        n = 0;
        while (Trig_o[1] !== 1'b1 && n < 100) begin @(negedge Clk_i); n++; end
        while (Trig_o[1] !== 1'b0 && n < 100) begin @(negedge Clk_i); n++; end
        checks++;
        if (n >= 100) begin
            errors++; $display("FAIL stuck_trigger: got no trigger pulse within 100 cycles want one");
        end else begin
            repeat (98) @(negedge Clk_i);
            checks++; if (Echo_sel_o !== 1'b1) begin errors++; $display("FAIL stuck_sel_before: got %b want 1", Echo_sel_o); end
            @(negedge Clk_i);
            checks++; if (Echo_sel_o !== 1'b0 || Echo_i[1] !== 1'b1) begin
                errors++; $display("FAIL stuck_sel_forced: got sel=%b pin=%b want sel=0 pin=1", Echo_sel_o, Echo_i[1]);
            end
            @(negedge Clk_i);
            checks++; if (Valid_o !== 1'b1 || Timeout_o !== 1'b1) begin
                errors++; $display("FAIL stuck_publish: got valid=%b timeout=%b want 1 1", Valid_o, Timeout_o);
            end
            checks++; if (Distance_o !== {DW{1'b1}} || Sensor_id_o !== 3'd1) begin
                errors++; $display("FAIL stuck_result: got dist=%0h id=%0d want all ones id=1", Distance_o, Sensor_id_o);
            end
            vcount = 0;
            repeat (60) begin @(negedge Clk_i); if (Valid_o === 1'b1) vcount++; end
            checks++; if (vcount != 0) begin errors++; $display("FAIL stuck_late_done: got %0d extra valids want 0", vcount); end
        end
        echo_len[1] = 40;
    endtask

    task automatic test_reset_mid_trigger();
        int n;
        do_reset(4'b0110);
        Enable_i = 1'b1;
        n = 0;
        while (Trig_o[1] !== 1'b1 && n < 50) begin @(negedge Clk_i); n++; end
        @(negedge Clk_i);
        #2 Reset_i = 1'b0;
        #1;
        checks++; if (Trig_o !== 4'b0000) begin errors++; $display("FAIL midrst_trig: got %b want 0000", Trig_o); end
        checks++; if (Busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", Busy_o); end
        repeat (3) @(negedge Clk_i);
        clear_logs();
        Reset_i = 1'b1;
        n = 0;
        while (trig_q.size() < 1 && n < 50) begin @(negedge Clk_i); n++; end
        checks++;
        if (trig_q.size() < 1) begin
            errors++; $display("FAIL midrst_restart: got no trigger want sensor 1");
        end else if (trig_q[0] != 1) begin
            errors++; $display("FAIL midrst_restart: got sensor %0d want 1", trig_q[0]);
        end
    endtask

    task automatic test_enable_drop();
        int n, busy_cnt, trig_cnt, vcount;
        do_reset(4'b0001);
        Enable_i = 1'b1;
        n = 0;
        while (Echo_sel_o !== 1'b1 && n < 100) begin @(negedge Clk_i); n++; end
        @(negedge Clk_i);
        Enable_i = 1'b0;
        n = 0;
        while (Valid_o !== 1'b1 && n < 200) begin @(negedge Clk_i); n++; end
        checks++;
        if (Valid_o !== 1'b1) begin
            errors++; $display("FAIL endrop_valid: got no result want one");
        end else begin
            checks++; if (Sensor_id_o !== 3'd0 || Distance_o !== DW'(1) || Timeout_o !== 1'b0) begin
                errors++; $display("FAIL endrop_result: got id=%0d dist=%0d to=%b want 0 1 0", Sensor_id_o, Distance_o, Timeout_o);
            end
            repeat (GAP - 1) @(negedge Clk_i);
            checks++; if (Busy_o !== 1'b1) begin errors++; $display("FAIL endrop_busy_gap: got %b want 1", Busy_o); end
            @(negedge Clk_i);
            checks++; if (Busy_o !== 1'b0) begin errors++; $display("FAIL endrop_busy_idle: got %b want 0", Busy_o); end
        end
        trig_cnt = 0;
        repeat (40) begin @(negedge Clk_i); if (Trig_o !== 4'b0000) trig_cnt++; end
        checks++; if (trig_cnt != 0) begin errors++; $display("FAIL endrop_stopped: got %0d trigger cycles want 0", trig_cnt); end

        do_reset(4'b0000);
        Enable_i = 1'b1;
        busy_cnt = 0; trig_cnt = 0; vcount = 0;
        repeat (200) begin
            @(negedge Clk_i);
            if (Busy_o !== 1'b0) busy_cnt++;
            if (Trig_o !== 4'b0000) trig_cnt++;
            if (Valid_o !== 1'b0) vcount++;
        end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL mask0_busy: got %0d busy cycles want 0", busy_cnt); end
        checks++; if (trig_cnt != 0) begin errors++; $display("FAIL mask0_trig: got %0d trigger cycles want 0", trig_cnt); end
        checks++; if (vcount != 0) begin errors++; $display("FAIL mask0_valid: got %0d valids want 0", vcount); end
        Enable_i = 1'b0;
    endtask

    initial begin : main
        test_reset();
        test_round_robin();
        test_mask_pattern();
        test_timeout_no_echo();
        test_stuck_echo();
        test_reset_mid_trigger();
        test_enable_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
